// File: rtl/juego_pkg.sv
// Shared definitions for the obstacle game.
//   - Main-FSM state encodings seen on the `presente` bus.
//   - Outcome codes driven on `W_or_L`.
//   - State type of the collision/lives tracker (colision_vidas).
package juego_pkg;

    // Main-FSM states as seen on `presente`.
    localparam logic [2:0] P_OFF  = 3'd0;
    localparam logic [2:0] P_WLCM = 3'd1;
    localparam logic [2:0] P_CH   = 3'd2;
    localparam logic [2:0] P_WL   = 3'd3;
    localparam logic [2:0] P_PA   = 3'd5;
    localparam logic [2:0] P_GAME = 3'd6;

    // Outcome codes on `W_or_L`; 2'b11 is never driven.
    localparam logic [1:0] WL_NONE = 2'b00;
    localparam logic [1:0] WL_LOSE = 2'b01;
    localparam logic [1:0] WL_WIN  = 2'b10;

    // colision_vidas FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_GRACE = 3'd2,
        S_LOSE  = 3'd3,
        S_WIN   = 3'd4
    } col_estado_t;

endpackage

// File: rtl/contador_gracia.sv
// Loadable down-counter with a zero flag, used as the post-hit grace timer.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset (count -> 0)
//   clr    - synchronous clear (count -> 0), same effect as rst
//   load   - load `valor` into the count (beats dec)
//   valor  - value to load
//   dec    - decrement by one; holds at 0
//   cuenta - current count
//   cero   - high when the count is 0
module contador_gracia #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] valor,
    input  logic         dec,
    output logic [W-1:0] cuenta,
    output logic         cero
);

    logic [W-1:0] cuenta_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cuenta_reg <= '0;
        end else if (load) begin
            cuenta_reg <= valor;
        end else if (dec && (cuenta_reg != '0)) begin
            cuenta_reg <= cuenta_reg - W'(1);
        end
    end

    assign cuenta = cuenta_reg;
    assign cero   = (cuenta_reg == '0);

endmodule

// File: rtl/colision_vidas.sv
// Collision and outcome tracker for the obstacle game.
// On every obstacle-advance tick the hero pattern is compared against one
// digit of the obstacle display. Hits cost a life and open a grace window;
// clean ticks add progress. Reaching META progress wins, losing the last
// life loses. Leaving the GAME state on `presente` returns to IDLE.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   tick         - single-cycle obstacle-advance strobe
//   presente     - current main-FSM state
//   display_obs  - obstacle segments, digit d at [d*SEG_W +: SEG_W]
//   heroe        - hero segments
//   W_or_L       - outcome: 00 playing, 01 lose, 10 win
//   vidas        - lives remaining
//   progreso     - survived ticks (saturates at META)
//   golpe        - one-cycle pulse per counted hit
//   invul        - high while the grace window is active
module colision_vidas
    import juego_pkg::*;
#(
    parameter int         SEG_W    = 7,
    parameter int         N_DIG    = 3,
    parameter int         HERO_DIG = 0,
    parameter int         VIDAS    = 3,
    parameter int         GRACIA   = 4,
    parameter int         META     = 64,
    parameter logic [2:0] GAME     = 3'd6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [2:0]                   presente,
    input  logic [SEG_W*N_DIG-1:0]       display_obs,
    input  logic [SEG_W-1:0]             heroe,
    output logic [1:0]                   W_or_L,
    output logic [$clog2(VIDAS+1)-1:0]   vidas,
    output logic [$clog2(META+1)-1:0]    progreso,
    output logic                         golpe,
    output logic                         invul
);

    localparam int V_W = $clog2(VIDAS + 1);
    localparam int P_W = $clog2(META + 1);
    // A zero-length grace window still needs a one-bit counter to exist.
    localparam int G_W = (GRACIA > 0) ? $clog2(GRACIA + 1) : 1;

    col_estado_t  estado_reg, estado_next;
    logic [V_W-1:0] vidas_reg, vidas_next;
    logic [P_W-1:0] progreso_reg, progreso_next;
    logic           golpe_reg, golpe_next;

    logic           hit;
    logic           g_load, g_dec, g_clr;
    logic [G_W-1:0] g_cuenta;
    logic           g_cero;

    assign hit = |(display_obs[HERO_DIG*SEG_W +: SEG_W] & heroe);

    contador_gracia #(
        .W(G_W)
    ) u_gracia (
        .clk    (clk),
        .rst    (rst),
        .clr    (g_clr),
        .load   (g_load),
        .valor  (G_W'(GRACIA)),
        .dec    (g_dec),
        .cuenta (g_cuenta),
        .cero   (g_cero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_reg   <= S_IDLE;
            vidas_reg    <= V_W'(VIDAS);
            progreso_reg <= '0;
            golpe_reg    <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            vidas_reg    <= vidas_next;
            progreso_reg <= progreso_next;
            golpe_reg    <= golpe_next;
        end
    end

    always_comb begin
        estado_next   = estado_reg;
        vidas_next    = vidas_reg;
        progreso_next = progreso_reg;
        golpe_next    = 1'b0;
        g_load        = 1'b0;
        g_dec         = 1'b0;
        g_clr         = 1'b0;

        if (presente != GAME) begin
            // Leaving the game always wins over any tick in flight.
            estado_next   = S_IDLE;
            vidas_next    = V_W'(VIDAS);
            progreso_next = '0;
            g_clr         = 1'b1;
        end else begin
            unique case (estado_reg)
                S_IDLE: begin
                    // A tick arriving together with GAME is deliberately dropped.
                    estado_next   = S_PLAY;
                    vidas_next    = V_W'(VIDAS);
                    progreso_next = '0;
                    g_clr         = 1'b1;
                end
                S_PLAY: begin
                    if (tick) begin
                        if (hit) begin
                            golpe_next = 1'b1;
                            if (vidas_reg != '0) begin
                                vidas_next = vidas_reg - V_W'(1);
                            end
                            if (vidas_reg <= V_W'(1)) begin
                                estado_next = S_LOSE;
                            end else if (GRACIA > 0) begin
                                estado_next = S_GRACE;
                                g_load      = 1'b1;
                            end
                        end else begin
                            if (progreso_reg < P_W'(META)) begin
                                progreso_next = progreso_reg + P_W'(1);
                            end
                            if (progreso_reg >= P_W'(META - 1)) begin
                                estado_next = S_WIN;
                            end
                        end
                    end
                end
                S_GRACE: begin
                    if (tick) begin
                        g_dec = 1'b1;
                        if (progreso_reg < P_W'(META)) begin
                            progreso_next = progreso_reg + P_W'(1);
                        end
                        // Win outranks the window expiring on the same tick.
                        if (progreso_reg >= P_W'(META - 1)) begin
                            estado_next = S_WIN;
                        end else if (g_cero || (g_cuenta == G_W'(1))) begin
                            estado_next = S_PLAY;
                        end
                    end
                end
                S_LOSE: estado_next = S_LOSE;
                S_WIN:  estado_next = S_WIN;
                default: estado_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        W_or_L = WL_NONE;
        if (estado_reg == S_LOSE) begin
            W_or_L = WL_LOSE;
        end else if (estado_reg == S_WIN) begin
            W_or_L = WL_WIN;
        end
    end

    assign vidas    = vidas_reg;
    assign progreso = progreso_reg;
    assign golpe    = golpe_reg;
    assign invul    = (estado_reg == S_GRACE);

endmodule
